// File: rtl/scfifo_arb_pkg.sv
// Purpose: shared types and round-robin helper for the FIFO drain arbiter.
// Latency: n/a (types and a combinational function only).
// Backpressure: n/a.
package scfifo_arb_pkg;

    localparam int MAX_CH = 16;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic       found;
        logic [3:0] idx;
    } rr_pick_t;

    // Rotate the request vector so the search starts just after last_ptr,
    // take the first set bit, and map it back to an absolute channel index.
    // The offsets are walked farthest-first so the nearest requester wins.
    function automatic rr_pick_t rr_pick(input logic [MAX_CH-1:0] req,
                                         input logic [3:0]        last_ptr,
                                         input int                n);
        rr_pick_t   r;
        logic [3:0] c;
        r = '0;
        for (int off = MAX_CH; off >= 1; off--) begin
            if (off <= n) begin
                c = 4'((int'(last_ptr) + off) % n);
                if (req[c]) begin
                    r.found = 1'b1;
                    r.idx   = c;
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Purpose: combinational round-robin picker over NUM_CH request lines.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller decides whether the pick is consumed.
module rr_priority_pick
    import scfifo_arb_pkg::*;
#(
    parameter int NUM_CH   = 8,
    parameter int CH_WIDTH = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0]   i_req,
    input  logic [CH_WIDTH-1:0] i_last_ptr,
    output logic                o_found,
    output logic [CH_WIDTH-1:0] o_idx
);

    rr_pick_t w_pick;
    logic     w_unused_idx;

    assign w_pick       = rr_pick(MAX_CH'(i_req), 4'(i_last_ptr), NUM_CH);
    assign o_found      = w_pick.found;
    assign o_idx        = w_pick.idx[CH_WIDTH-1:0];
    // Upper index bits are always zero for NUM_CH below 16.
    assign w_unused_idx = ^w_pick.idx;

endmodule

// File: rtl/scfifo_rr_drain_arbiter.sv
// Purpose: round-robin drain of NUM_CH show-ahead FIFOs onto one tagged stream, packet-atomic when PKT_MODE=1.
// Latency: 1 cycle from FIFO head to out_valid; one word per cycle sustained.
// Backpressure: out_ready=0 with out_valid held freezes the output register and suppresses all pops.
module scfifo_rr_drain_arbiter
    import scfifo_arb_pkg::*;
#(
    parameter int NUM_CH     = 8,
    parameter int DATA_WIDTH = 64,
    parameter int EOP_BIT    = DATA_WIDTH - 1,
    parameter int PKT_MODE   = 1,
    parameter int CH_WIDTH   = $clog2(NUM_CH)
) (
    input  logic                         clock,
    input  logic                         rst_n,
    input  logic [NUM_CH-1:0]            fifo_empty,
    input  logic [NUM_CH*DATA_WIDTH-1:0] fifo_q,
    output logic [NUM_CH-1:0]            fifo_rdreq,
    input  logic [NUM_CH-1:0]            ch_enable,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic [CH_WIDTH-1:0]          out_ch,
    output logic                         out_eop,
    output logic                         locked
);

    arb_state_e            r_state;
    arb_state_e            w_state_nxt;
    logic [CH_WIDTH-1:0]   r_lock_ch;
    logic [CH_WIDTH-1:0]   r_last_ptr;
    logic                  r_out_valid;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic [CH_WIDTH-1:0]   r_out_ch;

    logic [NUM_CH-1:0]     w_req;
    logic                  w_rr_found;
    logic [CH_WIDTH-1:0]   w_rr_idx;
    logic                  w_sel_vld;
    logic [CH_WIDTH-1:0]   w_sel;
    logic [DATA_WIDTH-1:0] w_head;
    logic                  w_eop;
    logic                  w_can_load;
    logic                  w_pop;

    // Enable only gates new grants; a locked channel bypasses this vector.
    assign w_req = ch_enable & ~fifo_empty;

    rr_priority_pick #(
        .NUM_CH   (NUM_CH),
        .CH_WIDTH (CH_WIDTH)
    ) u_pick (
        .i_req      (w_req),
        .i_last_ptr (r_last_ptr),
        .o_found    (w_rr_found),
        .o_idx      (w_rr_idx)
    );

    assign w_can_load = !r_out_valid || out_ready;

    // Channel selection: the locked channel mid-packet, otherwise the round-robin winner.
    always_comb begin
        w_sel     = w_rr_idx;
        w_sel_vld = w_rr_found;
        if (r_state == LOCK) begin
            w_sel     = r_lock_ch;
            w_sel_vld = 1'b1;
        end
    end

    // Head word of the selected FIFO and its end-of-packet flag.
    always_comb begin
        w_head = fifo_q[int'(w_sel)*DATA_WIDTH +: DATA_WIDTH];
    end
    assign w_eop = w_head[EOP_BIT];

    // A locked channel that ran dry stalls here rather than yielding the grant.
    assign w_pop = w_can_load && w_sel_vld && !fifo_empty[w_sel];

    // Pop strobe: one-hot on the selected channel, forced low while in reset.
    always_comb begin
        fifo_rdreq = '0;
        if (w_pop && rst_n) begin
            fifo_rdreq[w_sel] = 1'b1;
        end
    end

    // Next-state: lock on a non-EOP first word, release on the EOP word.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_pop && !w_eop && (PKT_MODE != 0)) w_state_nxt = LOCK;
            LOCK:    if (w_pop && w_eop) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Lock channel and round-robin pointer; pointer moves only at packet boundaries in packet mode.
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            r_lock_ch  <= '0;
            r_last_ptr <= CH_WIDTH'(NUM_CH - 1);
        end else begin
            if (w_pop && (r_state == IDLE)) begin
                r_lock_ch <= w_sel;
            end
            if (w_pop && ((PKT_MODE == 0) || w_eop)) begin
                r_last_ptr <= w_sel;
            end
        end
    end

    // Output register: load on pop, drain when the consumer takes the word and nothing replaces it.
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_ch    <= '0;
        end else if (w_pop) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_head;
            r_out_ch    <= w_sel;
        end else if (w_can_load) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_ch    = r_out_ch;
    assign out_eop   = r_out_data[EOP_BIT];
    assign locked    = (r_state == LOCK);

endmodule

// File: tb/tb_scfifo_rr_drain_arbiter.sv
// Purpose: self-checking bench for the drain arbiter, packet-mode and word-mode instances side by side.
// Latency: checks the one-cycle head-to-output latency against a queue-based reference model.
// Backpressure: exercises out_ready stalls, locked-channel starvation and enable drops.
module tb_scfifo_rr_drain_arbiter;

    localparam int NC = 8;
    localparam int DW = 16;

    logic clock = 1'b0;
    logic rst_n;
    always #5 clock = ~clock;

    // Index 0: PKT_MODE=1 instance, index 1: PKT_MODE=0 instance.
    logic [NC-1:0]    emp   [2];
    logic [NC*DW-1:0] fq    [2];
    logic [NC-1:0]    rdreq [2];
    logic [NC-1:0]    en    [2];
    logic             ov    [2];
    logic             ordy  [2];
    logic [DW-1:0]    od    [2];
    logic [2:0]       och   [2];
    logic             oeop  [2];
    logic             lck   [2];

    scfifo_rr_drain_arbiter #(.NUM_CH(NC), .DATA_WIDTH(DW), .EOP_BIT(DW-1), .PKT_MODE(1)) u_pkt (
        .clock(clock), .rst_n(rst_n), .fifo_empty(emp[0]), .fifo_q(fq[0]), .fifo_rdreq(rdreq[0]),
        .ch_enable(en[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od[0]),
        .out_ch(och[0]), .out_eop(oeop[0]), .locked(lck[0]));

    scfifo_rr_drain_arbiter #(.NUM_CH(NC), .DATA_WIDTH(DW), .EOP_BIT(DW-1), .PKT_MODE(0)) u_word (
        .clock(clock), .rst_n(rst_n), .fifo_empty(emp[1]), .fifo_q(fq[1]), .fifo_rdreq(rdreq[1]),
        .ch_enable(en[1]), .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od[1]),
        .out_ch(och[1]), .out_eop(oeop[1]), .locked(lck[1]));

    // FIFO contents and reference-model state.
    logic [DW-1:0] mq [2][NC][$];
    int            total = 0;
    int            bad   = 0;
    int            seqno = 0;
    int            cyc   = 0;
    logic          m_ov   [2];
    logic [DW-1:0] m_od   [2];
    int            m_och  [2];
    bit            m_lock [2];
    int            m_lch  [2];
    int            m_last [2];
    int            log_ch  [2][$];
    int            log_cyc [2][$];
    logic [NC-1:0] s_rd [2];
    logic [DW-1:0] s_od [2];

    typedef struct {
        int          d;
        logic [7:0]  en;
        logic [31:0] len;   // packet length per channel, one nibble each
        logic [31:0] cnt;   // packets per channel, one nibble each
        int          n;     // expected accepted words
        logic [63:0] seq;   // expected channel order, nibble k = word k
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic push_word(input int d, input int c, input bit eop);
        logic [DW-1:0] w;
        w = {eop, 3'(c), 12'(seqno)};
        seqno++;
        mq[d][c].push_back(w);
    endtask

    task automatic push_pkt(input int d, input int c, input int len);
        for (int i = 0; i < len; i++) push_word(d, c, i == len - 1);
    endtask

    task automatic model_reset(input int d);
        m_ov[d]   = 1'b0;
        m_od[d]   = '0;
        m_och[d]  = 0;
        m_lock[d] = 1'b0;
        m_lch[d]  = 0;
        m_last[d] = NC - 1;
    endtask

    task automatic drive();
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < NC; c++) begin
                emp[d][c] = (mq[d][c].size() == 0);
                fq[d][c*DW +: DW] = (mq[d][c].size() != 0) ? mq[d][c][0] : '0;
            end
        end
    endtask

    task automatic clear_logs();
        for (int d = 0; d < 2; d++) begin
            log_ch[d].delete();
            log_cyc[d].delete();
        end
    endtask

    // One clock: drive FIFO heads, check outputs and pop strobe at the falling edge,
    // advance the model, then let the FIFOs act on the sampled pop strobes.
    task automatic cycle();
        int            sel;
        int            c;
        bit            have;
        bit            can;
        bit            pop;
        logic [NC-1:0] exp_rd;
        logic [DW-1:0] w;
        drive();
        @(negedge clock);
        cyc++;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("d%0d out_valid", d), 64'(ov[d]), 64'(m_ov[d]));
            chk($sformatf("d%0d out_data", d), 64'(od[d]), 64'(m_od[d]));
            chk($sformatf("d%0d out_ch", d), 64'(och[d]), 64'(m_och[d]));
            chk($sformatf("d%0d out_eop", d), 64'(oeop[d]), 64'(m_od[d][DW-1]));
            chk($sformatf("d%0d locked", d), 64'(lck[d]), 64'(m_lock[d]));
            s_rd[d] = rdreq[d];
            s_od[d] = od[d];
            if (ov[d] && ordy[d]) begin
                log_ch[d].push_back(int'(och[d]));
                log_cyc[d].push_back(cyc);
            end
            can  = !m_ov[d] || ordy[d];
            have = 1'b0;
            sel  = 0;
            if (m_lock[d]) begin
                have = 1'b1;
                sel  = m_lch[d];
            end else begin
                for (int k = 1; k <= NC; k++) begin
                    c = (m_last[d] + k) % NC;
                    if (!have && en[d][c] && mq[d][c].size() > 0) begin
                        have = 1'b1;
                        sel  = c;
                    end
                end
            end
            pop    = rst_n && can && have && (mq[d][sel].size() > 0);
            exp_rd = pop ? NC'(1 << sel) : '0;
            chk($sformatf("d%0d fifo_rdreq", d), 64'(rdreq[d]), 64'(exp_rd));
            if (!rst_n) begin
                model_reset(d);
            end else if (pop) begin
                w        = mq[d][sel][0];
                m_ov[d]  = 1'b1;
                m_od[d]  = w;
                m_och[d] = sel;
                if (d == 0) begin
                    if (!m_lock[d] && !w[DW-1]) begin
                        m_lock[d] = 1'b1;
                        m_lch[d]  = sel;
                    end else if (m_lock[d] && w[DW-1]) begin
                        m_lock[d] = 1'b0;
                    end
                    if (w[DW-1]) m_last[d] = sel;
                end else begin
                    m_last[d] = sel;
                end
            end else if (can) begin
                m_ov[d] = 1'b0;
            end
        end
        @(posedge clock);
        #1;
        for (int d = 0; d < 2; d++)
            for (int k = 0; k < NC; k++)
                if (s_rd[d][k] && mq[d][k].size() > 0) void'(mq[d][k].pop_front());
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < NC; c++) mq[d][c].delete();
            en[d]   = '1;
            ordy[d] = 1'b1;
        end
        cycle();
        clear_logs();
    endtask

    task automatic check_seq(input int d, input string nm, input int n, input logic [63:0] seq, input bit contig);
        chk({nm, " count"}, 64'(log_ch[d].size()), 64'(n));
        for (int k = 0; k < n && k < log_ch[d].size(); k++)
            chk($sformatf("%s word%0d ch", nm, k), 64'(log_ch[d][k]), 64'(seq[k*4 +: 4]));
        if (contig && n > 0 && log_ch[d].size() == n)
            chk({nm, " no bubble"}, 64'(log_cyc[d][n-1] - log_cyc[d][0]), 64'(n - 1));
    endtask

    initial begin
        tbl[0] = '{d: 1, en: 8'hFF, len: 32'h0010_1001, cnt: 32'h0020_2002, n: 6, seq: 64'h530530};
        tbl[1] = '{d: 0, en: 8'hFF, len: 32'h0000_0240, cnt: 32'h0000_0110, n: 6, seq: 64'h221111};
        tbl[2] = '{d: 0, en: 8'hFF, len: 32'h1000_2001, cnt: 32'h1000_1002, n: 5, seq: 64'h07330};
        tbl[3] = '{d: 1, en: 8'hFF, len: 32'h0000_0230, cnt: 32'h0000_0110, n: 5, seq: 64'h12121};
        tbl[4] = '{d: 0, en: 8'hDF, len: 32'h0120_0000, cnt: 32'h0110_0000, n: 1, seq: 64'h6};
        tbl[5] = '{d: 1, en: 8'h00, len: 32'h0000_0100, cnt: 32'h0000_0100, n: 0, seq: 64'h0};

        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            model_reset(d);
            en[d]   = '1;
            ordy[d] = 1'b1;
        end

        // Reset with every FIFO holding a word: outputs and pop strobes stay low.
        for (int d = 0; d < 2; d++)
            for (int c = 0; c < NC; c++) push_word(d, c, 1'b1);
        cycle();
        cycle();
        rst_n = 1'b1;
        clear_logs();
        cycle();
        chk("first pop ch0 pkt", 64'(s_rd[0]), 64'h01);
        chk("first pop ch0 word", 64'(s_rd[1]), 64'h01);
        cycle();
        chk("first out count", 64'(log_ch[0].size()), 64'd1);
        if (log_ch[0].size() > 0) chk("first out_ch", 64'(log_ch[0][0]), 64'd0);

        // Table of preloaded FIFO patterns and the channel order they must drain in.
        for (int t = 0; t < 6; t++) begin
            apply_reset();
            en[tbl[t].d] = tbl[t].en;
            for (int c = 0; c < NC; c++)
                for (int p = 0; p < int'(tbl[t].cnt[c*4 +: 4]); p++)
                    push_pkt(tbl[t].d, c, int'(tbl[t].len[c*4 +: 4]));
            rst_n = 1'b1;
            for (int i = 0; i < 30; i++) cycle();
            check_seq(tbl[t].d, $sformatf("tbl%0d", t), tbl[t].n, tbl[t].seq, 1'b1);
        end

        // Locked channel runs dry mid-packet while another channel waits.
        apply_reset();
        push_word(0, 4, 1'b0);
        push_word(0, 4, 1'b0);
        push_pkt(0, 6, 3);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cycle();
            if (i >= 2) chk("stall rdreq", 64'(s_rd[0]), 64'd0);
        end
        push_word(0, 4, 1'b0);
        push_word(0, 4, 1'b0);
        push_word(0, 4, 1'b1);
        for (int i = 0; i < 15; i++) cycle();
        check_seq(0, "stall", 8, 64'h66644444, 1'b0);

        // Output held for ten cycles under backpressure.
        apply_reset();
        push_pkt(0, 1, 4);
        push_pkt(0, 5, 1);
        rst_n = 1'b1;
        cycle();
        cycle();
        ordy[0] = 1'b0;
        cycle();
        begin
            logic [DW-1:0] held;
            held = s_od[0];
            for (int i = 0; i < 10; i++) begin
                cycle();
                chk("hold data", 64'(s_od[0]), 64'(held));
                chk("hold rdreq", 64'(s_rd[0]), 64'd0);
            end
        end
        ordy[0] = 1'b1;
        for (int i = 0; i < 15; i++) cycle();
        check_seq(0, "backpressure", 5, 64'h51111, 1'b0);
        chk("backpressure ch1 drained", 64'(mq[0][1].size()), 64'd0);

        // Enable dropped on the locked channel mid-packet.
        apply_reset();
        push_pkt(0, 2, 3);
        push_pkt(0, 3, 2);
        push_pkt(0, 2, 1);
        rst_n = 1'b1;
        cycle();
        en[0][2] = 1'b0;
        for (int i = 0; i < 15; i++) cycle();
        check_seq(0, "en_drop", 5, 64'h33222, 1'b1);
        chk("en_drop ch2 left", 64'(mq[0][2].size()), 64'd1);

        // Random traffic, enables, backpressure and occasional reset against the model.
        apply_reset();
        rst_n = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            for (int d = 0; d < 2; d++) begin
                int c;
                c = int'($urandom_range(0, NC - 1));
                if ($urandom_range(0, 3) != 0 && mq[d][c].size() < 10)
                    push_word(d, c, $urandom_range(0, 2) == 0);
                ordy[d] = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 31) == 0) en[d][$urandom_range(0, NC - 1)] ^= 1'b1;
            end
            rst_n = ($urandom_range(0, 199) != 0);
            cycle();
        end
        rst_n = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/scfifo_rr_drain_arbiter.md
# scfifo_rr_drain_arbiter

Round-robin drain scheduler for a bank of NUM_CH show-ahead single-clock FIFOs (one per Ethernet channel) that merges them onto one registered valid/ready stream, tagged with the source channel. It sits between the per-channel `parameter_scfifo` instances and the shared downstream datapath. In packet mode it keeps the grant on one channel from the first word through the EOP word, so packets are never interleaved.

## Interface
Parameters:
- `NUM_CH`, 8, number of FIFO channels, 2..16.
- `DATA_WIDTH`, 64, FIFO word width, which includes the EOP flag.
- `EOP_BIT`, DATA_WIDTH-1, bit index of the end-of-packet flag inside each word.
- `PKT_MODE`, 1, 1 = grant held until the EOP word is popped; 0 = re-arbitrate every word.
- `CH_WIDTH`, $clog2(NUM_CH), width of the channel tag. Derived; do not override.

Ports:
- `clock`, in, 1, the single clock domain.
- `rst_n`, in, 1, synchronous active-low reset.
- `fifo_empty`, in, NUM_CH, per-channel FIFO empty flag.
- `fifo_q`, in, NUM_CH*DATA_WIDTH, per-channel show-ahead head word. Channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- `fifo_rdreq`, out, NUM_CH, per-channel pop strobe. One-hot or zero.
- `ch_enable`, in, NUM_CH, channel is eligible for new arbitration.
- `out_valid`, out, 1, out_data/out_ch hold a word.
- `out_ready`, in, 1, downstream accepts the word.
- `out_data`, out, DATA_WIDTH, registered word.
- `out_ch`, out, CH_WIDTH, source channel of out_data.
- `out_eop`, out, 1, copy of out_data[EOP_BIT].
- `locked`, out, 1, a packet is in progress (always 0 when PKT_MODE=0).

## Operation
- Two states:
  - IDLE: no channel locked.
  - LOCK: `lock_ch` holds the granted channel mid-packet.
- `can_load` = !out_valid || out_ready.
- Selected channel `sel`:
  - In LOCK, `sel` = lock_ch.
  - In IDLE, `sel` = first channel c with ch_enable[c] && !fifo_empty[c], scanning from last_ptr+1 and wrapping modulo NUM_CH.
- `pop` = can_load && a selected channel exists && !fifo_empty[sel]. When pop is true:
  - fifo_rdreq[sel] = 1.
  - Next cycle: out_data = fifo_q[sel], out_ch = sel, out_valid = 1.
- If can_load is true and there is no pop, out_valid clears next cycle.
- Transitions:
  - IDLE → LOCK on pop with eop = 0 and PKT_MODE = 1; lock_ch = sel.
  - LOCK → IDLE on pop with eop = 1.
  - In PKT_MODE = 0 the state never leaves IDLE.
- `last_ptr` update:
  - PKT_MODE = 1: last_ptr = sel on every pop with eop = 1, and on a single-word packet popped from IDLE.
  - PKT_MODE = 0: last_ptr = sel on every pop.
- Boundary rules:
  - Locked channel empty mid-packet: stall with no pop and no rdreq; other channels wait.
  - ch_enable[lock_ch] dropped mid-packet: ignored until EOP. Enable gates new grants only.
  - fifo_rdreq is never asserted for an empty FIFO, and never while rst_n = 0.
  - out_valid held with out_ready = 0: out_data and out_ch are stable, and no pop occurs.
  - No channel eligible in IDLE: no pop, and last_ptr is unchanged.

## Timing
- Reset values:
  - out_valid, out_data, out_ch, out_eop, locked: 0.
  - State: IDLE.
  - last_ptr: NUM_CH-1, so channel 0 wins first.
  - fifo_rdreq: 0.
- Latency: FIFO head to out_valid is 1 cycle (pop at cycle N, out_valid at N+1).
- Throughput: 1 word per cycle while out_ready = 1, including back-to-back packets on different channels (arbitration is combinational in IDLE, so no bubble).
- Reset asserted mid-packet: state returns to IDLE next cycle and the partially drained packet is abandoned. The FIFOs are reset separately by their owner.

## Structure
- Shared package `scfifo_arb_pkg`:
  - `arb_state_e` enum {IDLE, LOCK}.
  - Function `rr_pick(req, last_ptr)` returning {found, idx}.
- Sub-module `rr_priority_pick`: a combinational rotate / find-first / unrotate over NUM_CH. Instantiated once.
- Output register, state register and pointer logic live in the top module.

## Test plan
- Reset with all FIFOs non-empty and out_ready = 1 → first pop on ch0; out_valid rises 1 cycle later with out_ch = 0; all outputs are 0 during reset.
- PKT_MODE = 0, ch0/ch3/ch5 each hold 2 single-word entries → output channel order 0, 3, 5, 0, 3, 5 with no bubbles.
- PKT_MODE = 1, ch1 has a 4-word packet and ch2 a 2-word packet, both present → words 1, 1, 1, 1, 2, 2 contiguous; `locked` is high while ch1's first three words pop.
- Locked ch4 goes empty after word 2 of 5 while ch6 is full → stall with fifo_rdreq = 0 until ch4 refills; ch6 is not served until ch4's EOP.
- out_ready = 0 for 10 cycles with out_valid = 1 → out_data is stable, no fifo_rdreq, and no FIFO word is lost.
- ch_enable[2] cleared mid-packet on ch2 → packet completes; ch2 is skipped afterwards while ch3 is served.
